// File: rtl/mem_responder_if.sv
// Request/response bundle between the memory controller and mem_responder.
interface mem_responder_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writeData;
    logic              memoryReadEn;
    logic              memoryWriteEn;
    logic [DATA_W-1:0] readData;
    logic              memReady;
    logic              memBusy;
    logic              protocolErr;

    modport master (
        output address, writeData, memoryReadEn, memoryWriteEn,
        input  readData, memReady, memBusy, protocolErr
    );

    modport slave (
        input  address, writeData, memoryReadEn, memoryWriteEn,
        output readData, memReady, memBusy, protocolErr
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory with a one-cycle completion pulse.
// Accepts a single read or write from IDLE and ignores the enables while BUSY.
module mem_responder #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wr_q, wr_d;
    logic              ready_q, ready_d;
    logic              perr_q, perr_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        ready_d = 1'b0;
        perr_d  = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.memoryReadEn && bus.memoryWriteEn) begin
                    perr_d = 1'b1;
                end else if (bus.memoryReadEn || bus.memoryWriteEn) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                    addr_d  = bus.address;
                    wdata_d = bus.writeData;
                    wr_d    = bus.memoryWriteEn;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    if (wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_q[addr_q];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            perr_q  <= perr_d;
        end
    end

    // Storage is cleared by reset, so an aborted write can never leave stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign bus.readData    = rdata_q;
    assign bus.memReady    = ready_q;
    assign bus.memBusy     = (state_q == BUSY);
    assign bus.protocolErr = perr_q;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, corner sequences,
// and randomized traffic against a word-array reference model.
module tb_mem_responder;
    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 5;
    localparam int          LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();
    mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    mem_responder #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(LAT)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    mem_responder #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ref_mem [32];
    logic [7:0] ref_rd;

    typedef struct {
        bit         rd;
        bit         wr;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        bit         exp_perr;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        ref_rd = 8'h00;
    endfunction

    // Returns the readData value expected after the request completes.
    function automatic logic [7:0] model_apply(bit rd, bit wr, logic [4:0] a, logic [7:0] d);
        if (rd && wr) return ref_rd;
        if (wr) ref_mem[a] = d;
        else if (rd) ref_rd = ref_mem[a];
        return ref_rd;
    endfunction

    task automatic txn(input bit rd, input bit wr, input logic [4:0] a, input logic [7:0] d,
                       output int rdy_idx, output int rdy_cnt, output int busy_cnt,
                       output int perr_cnt, output logic [7:0] rdata);
        @(negedge clk);
        bus2.memoryReadEn  = rd;
        bus2.memoryWriteEn = wr;
        bus2.address       = a;
        bus2.writeData     = d;
        rdy_idx  = -1;
        rdy_cnt  = 0;
        busy_cnt = 0;
        perr_cnt = 0;
        rdata    = 8'h00;
        for (int j = 0; j < LAT + 3; j++) begin
            @(posedge clk);
            #1;
            if (bus2.memReady) begin
                rdy_cnt++;
                if (rdy_idx < 0) begin
                    rdy_idx = j;
                    rdata   = bus2.readData;
                end
            end
            busy_cnt += int'(bus2.memBusy);
            perr_cnt += int'(bus2.protocolErr);
            if (j == 0) begin
                bus2.memoryReadEn  = 1'b0;
                bus2.memoryWriteEn = 1'b0;
            end
        end
        if (rdy_idx < 0) rdata = bus2.readData;
    endtask

    task automatic txn_check(input string name, input bit rd, input bit wr, input logic [4:0] a,
                             input logic [7:0] d, input logic [7:0] exp_rdata, input bit exp_perr);
        int rdy_idx, rdy_cnt, busy_cnt, perr_cnt;
        logic [7:0] rdata;
        bit conflict;
        conflict = rd && wr;
        txn(rd, wr, a, d, rdy_idx, rdy_cnt, busy_cnt, perr_cnt, rdata);
        check({name, ".ready_at"},   rdy_idx,  conflict ? -1 : LAT);
        check({name, ".ready_cnt"},  rdy_cnt,  conflict ? 0 : 1);
        check({name, ".busy_cnt"},   busy_cnt, conflict ? 0 : LAT);
        check({name, ".perr_cnt"},   perr_cnt, exp_perr ? 1 : 0);
        check({name, ".readData"},   rdata,    exp_rdata);
    endtask

    int         b2b_edge [4];
    logic [7:0] b2b_data [4];
    int         b2b_n;

    task automatic b2b(input bit wr);
        b2b_n = 0;
        @(negedge clk);
        bus1.address       = 5'd0;
        bus1.writeData     = 8'h10;
        bus1.memoryReadEn  = !wr;
        bus1.memoryWriteEn = wr;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (bus1.memReady && b2b_n < 4) begin
                b2b_edge[b2b_n] = e;
                b2b_data[b2b_n] = bus1.readData;
                b2b_n++;
                if (b2b_n == 4) begin
                    bus1.memoryReadEn  = 1'b0;
                    bus1.memoryWriteEn = 1'b0;
                end else begin
                    bus1.address   = 5'(b2b_n);
                    bus1.writeData = 8'h10 + 8'(b2b_n);
                end
            end
        end
        bus1.memoryReadEn  = 1'b0;
        bus1.memoryWriteEn = 1'b0;
    endtask

    initial begin
        int cnt_r, cnt_b;
        logic [7:0] exp;

        vecs[0] = '{1'b1, 1'b0, 5'd7,  8'h00, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 5'd3,  8'hA5, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 5'd3,  8'h00, 8'hA5, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 5'd3,  8'h5A, 8'hA5, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 5'd3,  8'h00, 8'hA5, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 5'd31, 8'hFF, 8'hA5, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 5'd31, 8'h00, 8'hFF, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 5'd0,  8'h01, 8'hFF, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 5'd0,  8'h00, 8'h01, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 5'd7,  8'h00, 8'h00, 1'b0};

        bus2.memoryReadEn = 1'b0; bus2.memoryWriteEn = 1'b0;
        bus2.address = '0;        bus2.writeData = '0;
        bus1.memoryReadEn = 1'b0; bus1.memoryWriteEn = 1'b0;
        bus1.address = '0;        bus1.writeData = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset.readData",    bus2.readData,    8'h00);
        check("reset.memReady",    bus2.memReady,    1'b0);
        check("reset.memBusy",     bus2.memBusy,     1'b0);
        check("reset.protocolErr", bus2.protocolErr, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            exp = model_apply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            txn_check($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                      vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_perr);
        end

        // Enables and inputs wiggle during BUSY; only the original write may land.
        @(negedge clk);
        bus2.address = 5'd20; bus2.writeData = 8'h3C; bus2.memoryWriteEn = 1'b1;
        @(posedge clk);
        #1;
        cnt_r = int'(bus2.memReady);
        cnt_b = int'(bus2.memBusy);
        bus2.memoryWriteEn = 1'b0;
        bus2.address = 5'd21; bus2.writeData = 8'h77; bus2.memoryReadEn = 1'b1;
        @(posedge clk);
        #1;
        cnt_r += int'(bus2.memReady);
        cnt_b += int'(bus2.memBusy);
        bus2.memoryReadEn = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            cnt_r += int'(bus2.memReady);
            cnt_b += int'(bus2.memBusy);
        end
        check("busyign.ready_cnt", cnt_r, 1);
        check("busyign.busy_cnt",  cnt_b, LAT);
        exp = model_apply(1'b0, 1'b1, 5'd20, 8'h3C);
        exp = model_apply(1'b1, 1'b0, 5'd21, 8'h00);
        txn_check("busyign.rd21", 1'b1, 1'b0, 5'd21, 8'h00, exp, 1'b0);
        exp = model_apply(1'b1, 1'b0, 5'd20, 8'h00);
        txn_check("busyign.rd20", 1'b1, 1'b0, 5'd20, 8'h00, exp, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int unsigned op;
            bit rd, wr;
            logic [4:0] a;
            logic [7:0] d;
            op = $urandom_range(0, 9);
            rd = (op == 0) || (op >= 5);
            wr = (op <= 4);
            a  = 5'($urandom_range(0, 31));
            d  = 8'($urandom_range(0, 255));
            exp = model_apply(rd, wr, a, d);
            txn_check($sformatf("rnd%0d", i), rd, wr, a, d, exp, rd && wr);
        end

        exp = model_apply(1'b0, 1'b1, 5'd5, 8'hC3);
        txn_check("prerst.wr5", 1'b0, 1'b1, 5'd5, 8'hC3, exp, 1'b0);
        exp = model_apply(1'b1, 1'b0, 5'd5, 8'h00);
        txn_check("prerst.rd5", 1'b1, 1'b0, 5'd5, 8'h00, exp, 1'b0);

        // Reset lands mid-clock while a write is still counting down.
        @(negedge clk);
        bus2.address = 5'd12; bus2.writeData = 8'h99; bus2.memoryWriteEn = 1'b1;
        @(posedge clk);
        #1;
        bus2.memoryWriteEn = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst.readData",    bus2.readData,    8'h00);
        check("midrst.memReady",    bus2.memReady,    1'b0);
        check("midrst.memBusy",     bus2.memBusy,     1'b0);
        check("midrst.protocolErr", bus2.protocolErr, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        cnt_r = 0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            cnt_r += int'(bus2.memReady);
        end
        check("midrst.no_ready", cnt_r, 0);
        txn_check("midrst.rd12", 1'b1, 1'b0, 5'd12, 8'h00, 8'h00, 1'b0);
        txn_check("midrst.rd5",  1'b1, 1'b0, 5'd5,  8'h00, 8'h00, 1'b0);

        b2b(1'b1);
        check("b2b_wr.count", b2b_n, 4);
        b2b(1'b0);
        check("b2b_rd.count", b2b_n, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < b2b_n) begin
                check($sformatf("b2b_rd.edge%0d", i), b2b_edge[i], 2 * i + 1);
                check($sformatf("b2b_rd.data%0d", i), b2b_data[i], 8'h10 + 8'(i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Multicycle data-memory responder on the memory side of the CPU's memory interface. It accepts read and write requests from the controller's `memoryReadEn` / `memoryWriteEn` strobes. It models a fixed access latency, commits writes and returns read data with a one-cycle `memReady` completion pulse. It sits between the controller/datapath and the word-addressed storage array and gives the controller a completion handshake instead of fixed-cycle assumptions.

## Interface
- `DATA_W`, default 8: data word width.
- `ADDR_W`, default 5: address width; depth = 2**ADDR_W words.
- `LATENCY`, default 2: cycles from request acceptance to completion; legal range 1..15.

Ports:
- `clk`  in  1  single clock, all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `address`  in  ADDR_W  word address, sampled at acceptance.
- `writeData`  in  DATA_W  write data, sampled at acceptance.
- `memoryReadEn`  in  1  read request strobe from controller.
- `memoryWriteEn`  in  1  write request strobe from controller.
- `readData`  out  DATA_W  registered read data; holds last completed read.
- `memReady`  out  1  one-cycle completion pulse for the accepted request.
- `memBusy`  out  1  high while a request is in flight (state BUSY).
- `protocolErr`  out  1  one-cycle pulse when both enables are seen together in IDLE.

## Operation
- Reset: state=IDLE, counter=0, `readData`=0, `memReady`=0, `memBusy`=0, `protocolErr`=0, all array words cleared to 0.
- States: IDLE, BUSY.
- In IDLE, at a rising edge:
  - Exactly one enable high: accept the request. Latch `address`, `writeData` and the op (read/write). Load counter = LATENCY-1. Go to BUSY.
  - Both enables high: reject. Assert `protocolErr` for the next cycle, stay in IDLE, no array access.
  - Neither enable high: stay in IDLE.
- In BUSY, at a rising edge:
  - Counter > 0: decrement it.
  - Counter = 0: perform the latched op. A write commits the latched data to `array[latched address]`. A read loads `readData` from the array. Assert `memReady` for the following cycle and return to IDLE.
- Enables are ignored while in BUSY. No queueing, no error is flagged, and the latched request is unaffected by input changes.
- `readData` changes only on read completion or reset. Write completions leave it unchanged.
- Read-after-write to the same address in consecutive requests returns the newly written value.
- Asynchronous reset mid-operation aborts the request. A pending write is not committed. Outputs take their reset values immediately.
- `memBusy` = (state == BUSY). It is derived from registered state only, with no combinational path from the enables.

## Timing
- Request sampled at edge E0; completion at edge E0+LATENCY.
  - `memReady` is high for exactly one cycle, from E0+LATENCY to E0+LATENCY+1.
  - `readData` is valid from E0+LATENCY.
  - Write data is visible in the array from E0+LATENCY.
- `memBusy` is high from E0 to E0+LATENCY (LATENCY cycles).
- During the `memReady` cycle the block is in IDLE. A new request held during that cycle is accepted at E0+LATENCY+1, giving a maximum throughput of one access per LATENCY+1 cycles.
- The controller must hold its enable until it sees `memReady`, then drop it in the `memReady` cycle. An enable still high during the `memReady` cycle is taken as a new request.
- `protocolErr` rises at the edge after the conflicting sample and lasts one cycle.
- All outputs are registered or state-decoded; there are no input-to-output combinational paths.

## Test plan
- Reset: drive `rst`=0 mid-clock -> all outputs 0 immediately; after release, a read of address 7 returns 0x00.
- Write then read with LATENCY=2:
  - Write 0xA5 to address 3, accepted at E0 -> `memBusy` high for 2 cycles, `memReady` pulse at E0+2, `readData` stays 0.
  - Read of address 3 accepted at E0+3 -> `memReady` at E0+5, `readData`=0xA5.
- Busy ignore: during a write BUSY, change `address`/`writeData` and pulse `memoryReadEn` -> only the original write commits; exactly one `memReady` pulse.
- Conflict: both enables high in IDLE -> `protocolErr` pulse one cycle later, `memBusy` stays 0, array unchanged (read-back of that address returns its prior value).
- Reset mid-write: assert `rst` while in BUSY with counter > 0 -> no `memReady`; after release, reading the target address returns 0.
- LATENCY=1 back-to-back: hold `memoryReadEn` continuously on addresses 0..3 preloaded 0x10..0x13 -> `memReady` every 2nd cycle with `readData` 0x10, 0x11, 0x12, 0x13 in order.
